pht_port_ctrl: RTL and testbench

Controller that sequences a single-port, 1-cycle-read-latency pattern history table SRAM of 2-bit saturating counters. It time-shares the port between fetch-stage prediction lookups and retire-stage counter updates. It buffers updates in a small FIFO and performs each update as a read-modify-write. After every reset it sweeps the table to a known value. It sits between fetch/ROB-retire logic and the PHT macro inside the branch predictor.

---
 rtl/rv32i_types.sv | 15 +
 rtl/pht_port_ctrl_upd_fifo.sv | 35 +++
 rtl/pht_port_ctrl.sv | 100 ++++++++++
 tb/tb_pht_port_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared predictor types, PHT counter constants and the saturating-counter helper.
package rv32i_types;
  localparam int PHT_IDX_MAX = 16;
  typedef logic [1:0] pht_ctr_t;
  localparam pht_ctr_t PHT_CTR_INIT = 2'b01;
  typedef enum logic [1:0] {INIT, RUN, UPD_WR} pht_ctrl_state_t;
  // idx is sized for the widest table; controllers slice off the bits they use
  typedef struct packed {
    logic [PHT_IDX_MAX-1:0] idx;
    logic                   taken;
  } pht_upd_t;
  function automatic pht_ctr_t sat(input pht_ctr_t c, input logic taken);
    return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/pht_port_ctrl_upd_fifo.sv
// pht_upd_fifo: synchronous FIFO of retired branch updates, no same-cycle bypass.
module pht_upd_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  pht_upd_t din_i,
  input  logic     pop_i,
  output pht_upd_t dout_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  pht_upd_t    mem_q [DEPTH];
  // extra pointer bit distinguishes full from empty when the index bits match
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/pht_port_ctrl.sv
// pht_port_ctrl: single-port PHT sequencer (init sweep, lookups, buffered RMW updates).
// Optional perf counters enabled by defining PHT_CTRL_PERF_EN.
module pht_port_ctrl
  import rv32i_types::*;
#(
  parameter int IDX_W     = 4,
  parameter int UPD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             init_done,
`ifdef PHT_CTRL_PERF_EN
  output logic [31:0]      perf_lookup_stall,
  output logic [31:0]      perf_upd_full,
`endif
  output logic             pht_csb,
  output logic             pht_web,
  output logic [IDX_W-1:0] pht_addr,
  output logic [1:0]       pht_din,
  input  logic [1:0]       pht_dout
);
  pht_ctrl_state_t  state_q, state_d;
  logic [IDX_W-1:0] sweep_q, wr_idx_q;
  logic             wr_taken_q, init_done_q, pred_valid_q;
  logic             full, empty, run, upd_rd, fetch, push, unused_head;
  pht_upd_t         head, push_data;
  assign push_data   = '{idx: PHT_IDX_MAX'(upd_idx), taken: upd_taken};
  assign unused_head = ^head.idx;
  pht_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (push_data),
    .pop_i  (upd_rd),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  // every output is forced to its reset value while rst is held
  always_comb begin
    run          = (state_q == RUN) && !rst;
    upd_rd       = run && !empty && (full || !lookup_valid);
    fetch        = run && !full && lookup_valid;
    upd_ready    = rst || !full;
    push         = upd_valid && !full && !rst;
    lookup_ready = run && !full;
    state_d      = (state_q == INIT) ? (&sweep_q ? RUN : INIT) : (upd_rd ? UPD_WR : RUN);
    pht_csb      = rst || (run && !upd_rd && !lookup_valid);
    pht_web      = rst || (state_q == RUN);
    pht_addr     = rst ? '0 : (state_q == INIT) ? sweep_q : (state_q == UPD_WR) ? wr_idx_q :
                   upd_rd ? head.idx[IDX_W-1:0] : lookup_idx;
    pht_din      = (rst || state_q == RUN) ? 2'b00 : (state_q == INIT) ? PHT_CTR_INIT :
                   sat(pht_dout, wr_taken_q);
    pred_valid   = pred_valid_q && !rst;
    pred_taken   = pred_valid && pht_dout[1];
    init_done    = init_done_q && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      wr_idx_q     <= '0;
      wr_taken_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_q + IDX_W'(state_q == INIT);
      init_done_q  <= init_done_q || (state_q == INIT && &sweep_q);
      pred_valid_q <= fetch;
      if (upd_rd) begin
        wr_idx_q   <= head.idx[IDX_W-1:0];
        wr_taken_q <= head.taken;
      end
    end
  end
`ifdef PHT_CTRL_PERF_EN
  logic [31:0] stall_q, upd_full_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q    <= '0;
      upd_full_q <= '0;
    end else begin
      stall_q    <= stall_q + 32'(lookup_valid && !lookup_ready && !(&stall_q));
      upd_full_q <= upd_full_q + 32'(upd_valid && !upd_ready && !(&upd_full_q));
    end
  end
  assign perf_lookup_stall = stall_q;
  assign perf_upd_full     = upd_full_q;
`endif
endmodule

// File: tb/tb_pht_port_ctrl.sv
// tb_pht_port_ctrl: directed + random stimulus against a queue/array model of the PHT controller.
module tb_pht_port_ctrl;
  localparam int N = 16;
  localparam int D = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, lookup_valid, upd_valid, upd_taken;
  logic [3:0] lookup_idx, upd_idx;
  logic       lookup_ready, pred_valid, pred_taken, upd_ready, init_done, pht_csb, pht_web;
  logic [3:0] pht_addr;
  logic [1:0] pht_din, pht_dout;
`ifdef PHT_CTRL_PERF_EN
  logic [31:0] perf_lookup_stall, perf_upd_full;
`endif
  pht_port_ctrl #(.IDX_W(4), .UPD_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .init_done(init_done),
`ifdef PHT_CTRL_PERF_EN
    .perf_lookup_stall(perf_lookup_stall), .perf_upd_full(perf_upd_full),
`endif
    .pht_csb(pht_csb), .pht_web(pht_web), .pht_addr(pht_addr), .pht_din(pht_din), .pht_dout(pht_dout)
  );
  // SRAM macro: 1-cycle read latency, powers up with all counters strongly taken
  logic [1:0] sram [N];
  always @(posedge clk) begin
    if (!pht_csb) begin
      if (!pht_web) sram[pht_addr] <= pht_din;
      else pht_dout <= sram[pht_addr];
    end
  end
  typedef struct {int idx; bit t;} u_t;
  u_t q[$];
  int tab [N];
  int sweep, pidx, m_stall, m_full, total, bad;
  bit pend, ptk, pv, pvb;
  int log_a[$], log_d[$];
  int o_lr, o_pv, o_pt, o_ur, o_id, o_csb, o_web, o_addr, o_din, o_stall, o_full;

  function automatic int satm(int c, bit t);
    return t ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit lv, int li, bit uv, int ui, bit ut);
    bit init, wr, full, do_upd, fetch, e_lr, e_csb, e_web, push_ok;
    int e_addr, e_din;
    rst = r; lookup_valid = lv; lookup_idx = 4'(li);
    upd_valid = uv; upd_idx = 4'(ui); upd_taken = ut;
    @(negedge clk);
    init   = !r && sweep < N;
    wr     = !r && !init && pend;
    full   = q.size() == D;
    do_upd = !r && !init && !wr && q.size() > 0 && (full || !lv);
    fetch  = !r && !init && !wr && lv && !full;
    e_lr   = !r && !init && !wr && !full;
    e_csb  = !(init || wr || do_upd || fetch);
    e_web  = !(init || wr);
    e_addr = r ? 0 : init ? sweep : wr ? pidx : do_upd ? q[0].idx : li;
    e_din  = init ? 1 : wr ? satm(tab[pidx], ptk) : 0;
    chk("lookup_ready", lookup_ready, e_lr);
    chk("pred_valid", pred_valid, !r && pv);
    chk("pred_taken", pred_taken, !r && pv && pvb);
    chk("upd_ready", upd_ready, r || !full);
    chk("init_done", init_done, !r && sweep == N);
    chk("pht_csb", pht_csb, e_csb);
    chk("pht_web", pht_web, e_web);
    if (r || !e_csb) chk("pht_addr", pht_addr, e_addr);
    if (r || !e_web) chk("pht_din", pht_din, e_din);
`ifdef PHT_CTRL_PERF_EN
    if (!r) begin
      chk("perf_lookup_stall", perf_lookup_stall, m_stall);
      chk("perf_upd_full", perf_upd_full, m_full);
    end
    o_stall = perf_lookup_stall; o_full = perf_upd_full;
`endif
    o_lr = lookup_ready; o_pv = pred_valid; o_pt = pred_taken; o_ur = upd_ready; o_id = init_done;
    o_csb = pht_csb; o_web = pht_web; o_addr = pht_addr; o_din = pht_din;
    if (!pht_csb && !pht_web) begin log_a.push_back(pht_addr); log_d.push_back(pht_din); end
    @(posedge clk);
    if (r) begin
      sweep = 0; q.delete(); pend = 0; pv = 0; m_stall = 0; m_full = 0;
    end else begin
      push_ok = uv && !full;
      m_stall += int'(lv && !e_lr);
      m_full  += int'(uv && full);
      pv = fetch;
      if (fetch) pvb = tab[li][1];
      if (init) begin tab[sweep] = 1; sweep++; end
      if (wr) begin tab[pidx] = satm(tab[pidx], ptk); pend = 0; end
      if (do_upd) begin pidx = q[0].idx; ptk = q[0].t; void'(q.pop_front()); pend = 1; end
      if (push_ok) q.push_back('{idx: ui, t: ut});
    end
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_log();
    log_a.delete(); log_d.delete();
  endtask

  initial begin
    total = 0; bad = 0; sweep = 0; pend = 0; pv = 0; pvb = 0; m_stall = 0; m_full = 0;
    for (int i = 0; i < N; i++) begin sram[i] = 2'b11; tab[i] = 3; end
    pht_dout = 2'b00;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_csb", o_csb, 1);
    chk("rst_upd_ready", o_ur, 1);
    clr_log();
    idle(16);
    chk("sweep_writes", log_a.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("sweep_addr", log_a[i], i);
      chk("sweep_data", log_d[i], 1);
    end
    chk("init_done_c16", o_id, 0);
    idle(1);
    chk("init_done_c17", o_id, 1);
    cyc(0, 1, 5, 0, 0, 0);
    idle(1);
    chk("pred5_valid", o_pv, 1);
    chk("pred5_taken", o_pt, 0);
    clr_log();
    cyc(0, 0, 0, 1, 3, 1);
    cyc(0, 0, 0, 1, 3, 1);
    idle(6);
    chk("upd3_writes", log_a.size(), 2);
    chk("upd3_addr0", log_a[0], 3);
    chk("upd3_data0", log_d[0], 2);
    chk("upd3_data1", log_d[1], 3);
    cyc(0, 1, 3, 0, 0, 0);
    idle(1);
    chk("pred3_taken", o_pt, 1);
    clr_log();
    cyc(0, 0, 0, 1, 3, 1);
    idle(4);
    chk("upd3_sat_writes", log_a.size(), 1);
    chk("upd3_sat_data", log_d[0], 3);
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 1, 8 + i, i[0]);
    cyc(0, 1, 4, 0, 0, 0);
    chk("full_upd_ready", o_ur, 0);
    chk("full_lookup_ready", o_lr, 0);
    chk("full_upd_read_csb", o_csb, 0);
    chk("full_upd_read_web", o_web, 1);
    chk("full_upd_read_addr", o_addr, 8);
    cyc(0, 1, 5, 0, 0, 0);
    chk("updwr_lookup_ready", o_lr, 0);
    chk("updwr_web", o_web, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, i, 0, 0, 0);
    idle(12);
    cyc(0, 1, 6, 1, 7, 0);
    cyc(0, 1, 6, 0, 0, 0);
    chk("fetch_wins_pv", o_pv, 1);
    chk("fetch_wins_addr", o_addr, 6);
    chk("fetch_wins_web", o_web, 1);
    idle(1);
    chk("late_upd_addr", o_addr, 7);
    chk("late_upd_csb", o_csb, 0);
    idle(1);
    chk("late_upd_din", o_din, 0);
    chk("late_upd_web", o_web, 0);
    cyc(0, 1, 0, 1, 1, 1);
    cyc(0, 1, 0, 1, 2, 1);
    cyc(0, 1, 0, 1, 4, 1);
    cyc(0, 0, 0, 0, 0, 0);
    clr_log();
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_in_updwr_web", o_web, 1);
    idle(1);
    chk("resweep_addr", o_addr, 0);
    chk("resweep_din", o_din, 1);
    chk("resweep_upd_ready", o_ur, 1);
    idle(16);
    chk("resweep_no_upd_writes", log_a.size(), 16);
    repeat (3000)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 15),
          $urandom_range(0, 9) < 4, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    idle(30);
    for (int i = 0; i < N; i++) chk("table_contents", sram[i], tab[i]);
`ifdef PHT_CTRL_PERF_EN
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, i < 3, 0, 1, i, 1);
    idle(1);
    chk("perf_stall_3", o_stall, 3);
    chk("perf_full_2", o_full, 2);
    idle(30);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
